// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forward sequencer for the 3-stage pipeline: data-memory wait FSM with
// timeout error, stall-cycle counter and execute-stage operand forwarding select.
`default_nettype none

module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int RADDR_W     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [RADDR_W-1:0] rs1_execute_i,
    input  logic [RADDR_W-1:0] rs2_execute_i,
    input  logic               rs1_used_i,
    input  logic               rs2_used_i,
    input  logic [RADDR_W-1:0] rd_mem_i,
    input  logic               reg_wr_mem_i,
    input  logic               wb_sel_mem_i,
    input  logic               mem_req_mem_i,
    input  logic               dmem_ready_i,
    input  logic               br_taken_i,
    input  logic               err_clear_i,
    output logic               pc_stall_o,
    output logic               fd_stall_o,
    output logic               fd_flush_o,
    output logic               em_hold_o,
    output logic [1:0]         fwd_a_sel_o,
    output logic [1:0]         fwd_b_sel_o,
    output logic               mem_err_o,
    output logic [31:0]        stall_cycles_o
);

    localparam int                CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_ERR  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;
    logic               stall_raw;
    logic               stall;
    logic               match_a, match_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        stall_raw  = 1'b0;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_req_mem_i && !dmem_ready_i) begin
                    stall_raw  = 1'b1;
                    wait_cnt_d = CNT_W'(1);
                    state_d    = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    stall_raw = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ST_MEM_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_MEM_ERR: begin
                // err_clear wins over a coincident dmem_ready; the access is retried from RUN.
                stall_raw = 1'b1;
                if (err_clear_i) begin
                    state_d    = ST_RUN;
                    mem_err_d  = 1'b0;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // State is already RUN during reset, but a live request would still raise stall without this gate.
    assign stall = rst_n & stall_raw;

    assign stall_cycles_d = (stall && (stall_cycles_q != 32'hFFFF_FFFF))
                          ? stall_cycles_q + 32'd1 : stall_cycles_q;

    assign pc_stall_o     = stall;
    assign fd_stall_o     = stall;
    assign em_hold_o      = stall;
    assign fd_flush_o     = rst_n & br_taken_i & ~stall;
    assign mem_err_o      = mem_err_q;
    assign stall_cycles_o = stall_cycles_q;

    assign match_a = reg_wr_mem_i & (|rd_mem_i) & rs1_used_i & (rs1_execute_i == rd_mem_i);
    assign match_b = reg_wr_mem_i & (|rd_mem_i) & rs2_used_i & (rs2_execute_i == rd_mem_i);

    assign fwd_a_sel_o = match_a ? (wb_sel_mem_i ? 2'b10 : 2'b01) : 2'b00;
    assign fwd_b_sel_o = match_b ? (wb_sel_mem_i ? 2'b10 : 2'b01) : 2'b00;

endmodule

`default_nettype wire
